// File: rtl/cohort_arb_pkg.sv
// Shared types and constants for the cohort memory request arbiter.
// Source tags identify which generator owns each outstanding memory request.
package cohort_arb_pkg;

  typedef enum logic {
    SRC_PROD = 1'b0,
    SRC_CONS = 1'b1
  } src_t;

  localparam int unsigned DEFAULT_MAX_OUTSTANDING = 8;
  localparam int unsigned PERF_CNT_W              = 32;

  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] val,
                                                    input logic                  en);
    return (en && (val != '1)) ? val + 1'b1 : val;
  endfunction

endpackage

// File: rtl/cohort_tag_fifo.sv
// In-order FIFO of source tags for outstanding memory requests.
// Push is ignored when full and pop is ignored when empty; pop_data is read combinationally.
module cohort_tag_fifo
  import cohort_arb_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_MAX_OUTSTANDING
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  src_t                       push_data,
  input  logic                       pop,
  output src_t                       pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  src_t             mem_q [DEPTH];
  src_t             mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '{default: SRC_PROD};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cohort_mem_req_arbiter.sv
// Round-robin arbiter sharing one memory request channel between producer writes and consumer reads.
// Define COHORT_ARB_PERF_EN to add saturating grant and full-stall performance counters.
module cohort_mem_req_arbiter
  import cohort_arb_pkg::*;
#(
  parameter int unsigned ADDR_W          = 64,
  parameter int unsigned DATA_W          = 64,
  parameter int unsigned MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               prod_req_valid,
  output logic                               prod_req_ready,
  input  logic [ADDR_W-1:0]                  prod_req_addr,
  input  logic                               cons_req_valid,
  output logic                               cons_req_ready,
  input  logic [ADDR_W-1:0]                  cons_req_addr,
  output logic                               mem_req_valid,
  input  logic                               mem_req_ready,
  output logic [ADDR_W-1:0]                  mem_req_addr,
  output logic                               mem_req_we,
  input  logic                               mem_resp_valid,
  input  logic [DATA_W-1:0]                  mem_resp_data,
  output logic                               prod_ack,
  output logic                               cons_resp_valid,
  output logic [DATA_W-1:0]                  cons_resp_data,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_cnt,
  output logic                               err_spurious_resp
`ifdef COHORT_ARB_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0]              perf_prod_grants,
  output logic [PERF_CNT_W-1:0]              perf_cons_grants,
  output logic [PERF_CNT_W-1:0]              perf_full_stall
`endif
);

  src_t              rr_prio_q, rr_prio_d;
  src_t              grant_src;
  src_t              pop_tag;
  logic              tag_full, tag_empty;
  logic              can_issue, any_valid, handshake;
  logic              resp_pop, resp_spurious;
  logic              prod_ack_q, prod_ack_d;
  logic              cons_resp_valid_q, cons_resp_valid_d;
  logic [DATA_W-1:0] cons_resp_data_q, cons_resp_data_d;
  logic              err_q, err_d;

  // Full is judged on the pre-pop count, so a same-cycle response never frees a slot for issue.
  assign can_issue = ~tag_full;
  assign any_valid = prod_req_valid | cons_req_valid;

  always_comb begin
    grant_src = SRC_CONS;
    if (prod_req_valid && cons_req_valid) begin
      grant_src = rr_prio_q;
    end else if (prod_req_valid) begin
      grant_src = SRC_PROD;
    end
  end

  assign mem_req_valid  = can_issue & any_valid;
  assign mem_req_addr   = (grant_src == SRC_CONS) ? cons_req_addr : prod_req_addr;
  assign mem_req_we     = mem_req_valid & (grant_src == SRC_PROD);
  assign handshake      = mem_req_valid & mem_req_ready;
  assign prod_req_ready = handshake & (grant_src == SRC_PROD);
  assign cons_req_ready = handshake & (grant_src == SRC_CONS);

  assign resp_pop      = mem_resp_valid & ~tag_empty;
  assign resp_spurious = mem_resp_valid & tag_empty;

  cohort_tag_fifo #(
    .DEPTH     (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (handshake),
    .push_data (grant_src),
    .pop       (resp_pop),
    .pop_data  (pop_tag),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (outstanding_cnt)
  );

  always_comb begin
    rr_prio_d         = rr_prio_q;
    prod_ack_d        = 1'b0;
    cons_resp_valid_d = 1'b0;
    cons_resp_data_d  = cons_resp_data_q;
    err_d             = err_q | resp_spurious;
    if (handshake) begin
      rr_prio_d = (grant_src == SRC_PROD) ? SRC_CONS : SRC_PROD;
    end
    if (resp_pop) begin
      if (pop_tag == SRC_CONS) begin
        cons_resp_valid_d = 1'b1;
        cons_resp_data_d  = mem_resp_data;
      end else begin
        prod_ack_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_prio_q         <= SRC_PROD;
      prod_ack_q        <= 1'b0;
      cons_resp_valid_q <= 1'b0;
      cons_resp_data_q  <= '0;
      err_q             <= 1'b0;
    end else begin
      rr_prio_q         <= rr_prio_d;
      prod_ack_q        <= prod_ack_d;
      cons_resp_valid_q <= cons_resp_valid_d;
      cons_resp_data_q  <= cons_resp_data_d;
      err_q             <= err_d;
    end
  end

  assign prod_ack          = prod_ack_q;
  assign cons_resp_valid   = cons_resp_valid_q;
  assign cons_resp_data    = cons_resp_data_q;
  assign err_spurious_resp = err_q;

`ifdef COHORT_ARB_PERF_EN
  logic [PERF_CNT_W-1:0] perf_prod_grants_q, perf_prod_grants_d;
  logic [PERF_CNT_W-1:0] perf_cons_grants_q, perf_cons_grants_d;
  logic [PERF_CNT_W-1:0] perf_full_stall_q, perf_full_stall_d;

  always_comb begin
    perf_prod_grants_d = sat_inc(perf_prod_grants_q, handshake & (grant_src == SRC_PROD));
    perf_cons_grants_d = sat_inc(perf_cons_grants_q, handshake & (grant_src == SRC_CONS));
    perf_full_stall_d  = sat_inc(perf_full_stall_q, any_valid & tag_full);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_prod_grants_q <= '0;
      perf_cons_grants_q <= '0;
      perf_full_stall_q  <= '0;
    end else begin
      perf_prod_grants_q <= perf_prod_grants_d;
      perf_cons_grants_q <= perf_cons_grants_d;
      perf_full_stall_q  <= perf_full_stall_d;
    end
  end

  assign perf_prod_grants = perf_prod_grants_q;
  assign perf_cons_grants = perf_cons_grants_q;
  assign perf_full_stall  = perf_full_stall_q;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_cohort_mem_req_arbiter.sv
// Self-checking bench for cohort_mem_req_arbiter: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based reference model of the arbitration and response routing.
module tb_cohort_mem_req_arbiter;

  localparam int ADDR_W  = 64;
  localparam int DATA_W  = 64;
  localparam int MAX_OUT = 8;
  localparam int CNT_W   = $clog2(MAX_OUT) + 1;

  logic              clk;
  logic              rst_n;
  logic              prod_req_valid;
  logic              prod_req_ready;
  logic [ADDR_W-1:0] prod_req_addr;
  logic              cons_req_valid;
  logic              cons_req_ready;
  logic [ADDR_W-1:0] cons_req_addr;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_we;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;
  logic              prod_ack;
  logic              cons_resp_valid;
  logic [DATA_W-1:0] cons_resp_data;
  logic [CNT_W-1:0]  outstanding_cnt;
  logic              err_spurious_resp;

  cohort_mem_req_arbiter #(
    .ADDR_W            (ADDR_W),
    .DATA_W            (DATA_W),
    .MAX_OUTSTANDING   (MAX_OUT)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .prod_req_valid    (prod_req_valid),
    .prod_req_ready    (prod_req_ready),
    .prod_req_addr     (prod_req_addr),
    .cons_req_valid    (cons_req_valid),
    .cons_req_ready    (cons_req_ready),
    .cons_req_addr     (cons_req_addr),
    .mem_req_valid     (mem_req_valid),
    .mem_req_ready     (mem_req_ready),
    .mem_req_addr      (mem_req_addr),
    .mem_req_we        (mem_req_we),
    .mem_resp_valid    (mem_resp_valid),
    .mem_resp_data     (mem_resp_data),
    .prod_ack          (prod_ack),
    .cons_resp_valid   (cons_resp_valid),
    .cons_resp_data    (cons_resp_data),
    .outstanding_cnt   (outstanding_cnt),
    .err_spurious_resp (err_spurious_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model: owner of each in-flight request (0=producer, 1=consumer), oldest first.
  bit              tagQ[$];
  bit              prio;
  bit              expErr;
  bit              expAck;
  bit              expConsValid;
  logic [DATA_W-1:0] expConsData;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic checkRegistered();
    checkOutput("prod_ack", prod_ack, expAck);
    checkOutput("cons_resp_valid", cons_resp_valid, expConsValid);
    checkOutput("cons_resp_data", cons_resp_data, expConsData);
    checkOutput("outstanding_cnt", outstanding_cnt, tagQ.size());
    checkOutput("err_spurious_resp", err_spurious_resp, expErr);
  endtask

  // Drives one cycle of inputs, checks the request side, advances the model, then checks responses.
  task automatic applyStimulus(input bit pv, input logic [63:0] pa, input bit cv, input logic [63:0] ca,
                               input bit mr, input bit rv, input logic [63:0] rd);
    bit canIssue, grant, expValid, hs, t;
    prod_req_valid = pv;
    prod_req_addr  = pa;
    cons_req_valid = cv;
    cons_req_addr  = ca;
    mem_req_ready  = mr;
    mem_resp_valid = rv;
    mem_resp_data  = rd;
    #2;
    canIssue = (tagQ.size() < MAX_OUT);
    grant    = (pv && cv) ? prio : !pv;
    expValid = canIssue && (pv || cv);
    hs       = expValid && mr;
    checkOutput("mem_req_valid", mem_req_valid, expValid);
    if (expValid) begin
      checkOutput("mem_req_we", mem_req_we, !grant);
      checkOutput("mem_req_addr", mem_req_addr, grant ? ca : pa);
    end
    checkOutput("prod_req_ready", prod_req_ready, hs && !grant);
    checkOutput("cons_req_ready", cons_req_ready, hs && grant);
    expAck       = 1'b0;
    expConsValid = 1'b0;
    if (rv) begin
      if (tagQ.size() == 0) begin
        expErr = 1'b1;
      end else begin
        t = tagQ.pop_front();
        if (t) begin
          expConsValid = 1'b1;
          expConsData  = rd;
        end else begin
          expAck = 1'b1;
        end
      end
    end
    if (hs) begin
      tagQ.push_back(grant);
      prio = !grant;
    end
    @(posedge clk);
    #1;
    checkRegistered();
  endtask

  task automatic doReset();
    rst_n          = 1'b0;
    prod_req_valid = 1'b0;
    prod_req_addr  = '0;
    cons_req_valid = 1'b0;
    cons_req_addr  = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    tagQ.delete();
    prio         = 1'b0;
    expErr       = 1'b0;
    expAck       = 1'b0;
    expConsValid = 1'b0;
    expConsData  = '0;
    rst_n        = 1'b1;
    checkRegistered();
    checkOutput("reset mem_req_valid", mem_req_valid, 1'b0);
    checkOutput("reset prod_req_ready", prod_req_ready, 1'b0);
    checkOutput("reset cons_req_ready", cons_req_ready, 1'b0);
  endtask

  initial begin
    int pvProb, cvProb, mrProb, rvProb;
    doReset();

    // Both sources always valid, responses once two are in flight: strict P,C alternation.
    for (int i = 0; i < 12; i++)
      applyStimulus(1, rnd64(), 1, rnd64(), 1, tagQ.size() >= 2, rnd64());

    // Producer alone fills the tag FIFO, then a response and a request meet while full.
    doReset();
    for (int i = 0; i < 9; i++) applyStimulus(1, rnd64(), 0, '0, 1, 0, '0);
    applyStimulus(1, rnd64(), 0, '0, 1, 1, '0);
    applyStimulus(1, rnd64(), 0, '0, 1, 0, '0);
    for (int i = 0; i < 9; i++) applyStimulus(0, '0, 0, '0, 1, 1, rnd64());

    // Consumer reads with known data.
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(0, '0, 1, 64'h1000 + i, 1, 0, '0);
    applyStimulus(0, '0, 0, '0, 1, 1, 64'hA);
    applyStimulus(0, '0, 0, '0, 1, 1, 64'hB);
    applyStimulus(0, '0, 0, '0, 1, 1, 64'hC);
    applyStimulus(0, '0, 0, '0, 1, 0, 64'hD);

    // Stalled memory with both valid: grant and priority must hold until the handshake.
    for (int i = 0; i < 4; i++) applyStimulus(1, 64'h50, 1, 64'h60, 0, 0, '0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 64'h50, 1, 64'h60, 1, 0, '0);

    // Spurious response on an empty FIFO sets a sticky flag.
    doReset();
    applyStimulus(0, '0, 0, '0, 1, 1, 64'hDEAD);
    for (int i = 0; i < 3; i++) applyStimulus(0, '0, 0, '0, 1, 0, '0);

    // Reset while requests are in flight: late responses become spurious.
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1, rnd64(), 1, rnd64(), 1, 0, '0);
    doReset();
    applyStimulus(0, '0, 0, '0, 1, 1, rnd64());
    applyStimulus(0, '0, 0, '0, 1, 1, rnd64());

    // Randomized traffic with changing load profiles.
    doReset();
    for (int phase = 0; phase < 8; phase++) begin
      pvProb = $urandom_range(10, 100);
      cvProb = $urandom_range(10, 100);
      mrProb = $urandom_range(30, 100);
      rvProb = (phase % 3 == 0) ? 10 : $urandom_range(20, 90);
      for (int i = 0; i < 100; i++)
        applyStimulus($urandom_range(0, 99) < pvProb, rnd64(),
                      $urandom_range(0, 99) < cvProb, rnd64(),
                      $urandom_range(0, 99) < mrProb,
                      (tagQ.size() > 0) && ($urandom_range(0, 99) < rvProb), rnd64());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/cohort_mem_req_arbiter.md
Name: cohort_mem_req_arbiter

Overview:
Shares one memory request channel between the producer transaction generator (writes to FIFO slots) and the consumer transaction generator (reads from FIFO slots).
- Arbitration is round-robin.
- An in-order tag FIFO tracks outstanding requests and routes in-order memory responses back as a producer ack pulse (drives trans_ack) or as consumer read data.
- Sits between the per-tile producer/consumer units and the tile memory/NoC interface.

Parameters:
ADDR_W, 64, request address width
DATA_W, 64, consumer response data width
MAX_OUTSTANDING, 8, tag FIFO depth; power of two, ≥2

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
prod_req_valid  in  1  producer write request valid
prod_req_ready  out  1  producer request accepted this cycle
prod_req_addr  in  ADDR_W  producer slot address
cons_req_valid  in  1  consumer read request valid
cons_req_ready  out  1  consumer request accepted this cycle
cons_req_addr  in  ADDR_W  consumer slot address
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_W  granted address
mem_req_we  out  1  1=write (producer), 0=read (consumer)
mem_resp_valid  in  1  in-order response, single-cycle pulse
mem_resp_data  in  DATA_W  read data (ignored for writes)
prod_ack  out  1  registered one-cycle ack to producer
cons_resp_valid  out  1  registered consumer data valid
cons_resp_data  out  DATA_W  registered consumer data
outstanding_cnt  out  $clog2(MAX_OUTSTANDING)+1  requests in flight
err_spurious_resp  out  1  sticky error flag

Behaviour:
- Reset: all outputs 0; tag FIFO empty; rr_prio=PROD; err flag cleared.
- can_issue = !tag_full. The count used is the pre-pop value: a response in the same cycle does not free a slot for issue.
- Grant (combinational):
  - Both valid: the source indicated by rr_prio wins.
  - Only one valid: that source wins.
  - No grant when !can_issue.
- mem_req_valid = can_issue & (prod_req_valid | cons_req_valid).
- mem_req_addr and mem_req_we are muxed from the granted source.
- Ready signals: the granted source's ready = mem_req_ready & can_issue; the other source's ready = 0. No valid→ready combinational loop beyond this mux.
- Handshake (mem_req_valid & mem_req_ready):
  - Push granted source tag (PROD/CONS) into the tag FIFO.
  - rr_prio flips to the non-granted source.
  - rr_prio changes only on a handshake; a stalled grant holds priority.
- Response (mem_resp_valid):
  - Pop tag.
  - Next cycle, assert prod_ack=1 if tag=PROD, or cons_resp_valid=1 with cons_resp_data captured if tag=CONS. Latency is exactly 1 cycle.
  - cons_resp_data holds its last value otherwise.
- Response with FIFO empty: ignored; no ack; err_spurious_resp set and held until reset.
- Simultaneous push and pop: count unchanged; both pointers advance; wrap modulo MAX_OUTSTANDING.
- outstanding_cnt is the registered FIFO count; range 0..MAX_OUTSTANDING.
- Reset mid-operation: in-flight tags are discarded. Responses after reset for pre-reset requests are flagged spurious.
- Requesters may drop valid without a handshake; the arbiter keeps no memory of unaccepted requests.

Optional Feature:
COHORT_ARB_PERF_EN
- Defined: adds 32-bit saturating output counters perf_prod_grants, perf_cons_grants (increment on handshake per source) and perf_full_stall (cycles with any request valid & tag_full). All reset to 0.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Package cohort_arb_pkg: src_t enum {SRC_PROD=1'b0, SRC_CONS=1'b1}; default depth constant; counter width constant.
- Sub-module cohort_tag_fifo: parameterised-depth, 1-bit-wide synchronous FIFO exposing full, empty and count. The arbiter instantiates it once.

Test Plan:
- Both sources continuously valid, mem_req_ready=1, responses 2 cycles later: grants alternate P,C,P,C; prod_ack and cons_resp_valid alternate, each one cycle after its response.
- Producer only, 9 requests, no responses: 8 handshakes; outstanding_cnt=8; prod_req_ready=0 on the 9th. One response frees a slot; the 9th is issued the following cycle.
- Count=8 with response and new request in the same cycle: no issue that cycle; issue next cycle; count goes 8→7→8.
- Consumer issues 3 reads; responses carry data 0xA, 0xB, 0xC: cons_resp_data sequence is 0xA, 0xB, 0xC, each with valid one cycle after its response; prod_ack stays 0.
- mem_resp_valid while empty: no ack; err_spurious_resp=1 and stays set; cleared only by rst_n=0.
- mem_req_ready=0 for 4 cycles with both sources valid: the grant holds the same source; rr_prio unchanged until the handshake.
